// File: rtl/mips_mem_arbiter_if.sv
// Shared single-port memory bus between mips_mem_arbiter (master) and the memory (slave).
interface mips_mem_arbiter_if;
  logic [31:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_writedata;
  logic        bus_waitrequest;
  logic [31:0] bus_readdata;

  modport master (
    output bus_address, bus_read, bus_write, bus_writedata,
    input  bus_waitrequest, bus_readdata
  );

  modport slave (
    input  bus_address, bus_read, bus_write, bus_writedata,
    output bus_waitrequest, bus_readdata
  );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Multicycle fetch/decode/data/commit sequencer sharing one memory bus for a Harvard MIPS CPU.
// Optional bus-access timeout with sticky error state: define MEM_ARB_TIMEOUT_EN.
module mips_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_active,
  output logic        cpu_clk_enable,
  input  logic [31:0] cpu_instr_address,
  output logic [31:0] cpu_instr_readdata,
  input  logic [31:0] cpu_data_address,
  input  logic        cpu_data_read,
  input  logic        cpu_data_write,
  input  logic [31:0] cpu_data_writedata,
  output logic [31:0] cpu_data_readdata,
  mips_mem_arbiter_if.master bus,
  output logic [31:0] instr_count,
  output logic        bus_error
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    DATA,
    COMMIT
`ifdef MEM_ARB_TIMEOUT_EN
    , ERR
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ird_q, ird_d;
  logic [31:0] drd_q, drd_d;
  logic [31:0] cnt_q, cnt_d;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic              timed_out;

  // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle of an access.
  assign timed_out = bus.bus_waitrequest && (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    ird_d   = ird_q;
    drd_d   = drd_q;
    cnt_d   = cnt_q;
`ifdef MEM_ARB_TIMEOUT_EN
    wait_d  = wait_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (cpu_active) begin
          addr_d  = cpu_instr_address;
          rd_d    = 1'b1;
          state_d = FETCH;
`ifdef MEM_ARB_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
      end
      FETCH: begin
        if (!bus.bus_waitrequest) begin
          ird_d   = bus.bus_readdata;
          rd_d    = 1'b0;
          state_d = DECODE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (timed_out) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          wait_d  = wait_q + 1'b1;
        end
`endif
      end
      DECODE: begin
        // A store takes priority; a simultaneous load request is dropped.
        if (cpu_data_write) begin
          addr_d  = cpu_data_address;
          wdata_d = cpu_data_writedata;
          wr_d    = 1'b1;
          state_d = DATA;
        end else if (cpu_data_read) begin
          addr_d  = cpu_data_address;
          rd_d    = 1'b1;
          state_d = DATA;
        end else begin
          state_d = COMMIT;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        wait_d = '0;
`endif
      end
      DATA: begin
        if (!bus.bus_waitrequest) begin
          if (rd_q) drd_d = bus.bus_readdata;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = COMMIT;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (timed_out) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          wait_d  = wait_q + 1'b1;
        end
`endif
      end
      COMMIT: begin
        cnt_d   = cnt_q + 32'd1;
        state_d = IDLE;
      end
`ifdef MEM_ARB_TIMEOUT_EN
      ERR: state_d = ERR;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      ird_q   <= '0;
      drd_q   <= '0;
      cnt_q   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      ird_q   <= ird_d;
      drd_q   <= drd_d;
      cnt_q   <= cnt_d;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_q  <= wait_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.bus_address   = addr_q;
  assign bus.bus_read      = rd_q;
  assign bus.bus_write     = wr_q;
  assign bus.bus_writedata = wdata_q;
  assign cpu_instr_readdata = ird_q;
  assign cpu_data_readdata  = drd_q;
  assign instr_count        = cnt_q;
  assign cpu_clk_enable     = (state_q == COMMIT);

`ifdef MEM_ARB_TIMEOUT_EN
  assign bus_error = err_q;
`else
  assign bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: idle, NOP, stalled load, store priority, async reset, timeout.
module tb_mips_mem_arbiter;
  logic        clk;
  logic        reset;
  logic        cpu_active;
  logic        cpu_clk_enable;
  logic [31:0] cpu_instr_address;
  logic [31:0] cpu_instr_readdata;
  logic [31:0] cpu_data_address;
  logic        cpu_data_read;
  logic        cpu_data_write;
  logic [31:0] cpu_data_writedata;
  logic [31:0] cpu_data_readdata;
  logic [31:0] instr_count;
  logic        bus_error;

  int errors = 0;
  int checks = 0;

  mips_mem_arbiter_if bus_if ();

  mips_mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .cpu_active        (cpu_active),
    .cpu_clk_enable    (cpu_clk_enable),
    .cpu_instr_address (cpu_instr_address),
    .cpu_instr_readdata(cpu_instr_readdata),
    .cpu_data_address  (cpu_data_address),
    .cpu_data_read     (cpu_data_read),
    .cpu_data_write    (cpu_data_write),
    .cpu_data_writedata(cpu_data_writedata),
    .cpu_data_readdata (cpu_data_readdata),
    .bus               (bus_if.master),
    .instr_count       (instr_count),
    .bus_error         (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    cpu_active = 1'b0;
    cpu_instr_address = '0;
    cpu_data_address = '0;
    cpu_data_read = 1'b0;
    cpu_data_write = 1'b0;
    cpu_data_writedata = '0;
    bus_if.bus_waitrequest = 1'b0;
    bus_if.bus_readdata = '0;
    step();
    step();
    check("rst_read", bus_if.bus_read, 0);
    check("rst_write", bus_if.bus_write, 0);
    check("rst_addr", bus_if.bus_address, 0);
    check("rst_count", instr_count, 0);
    check("rst_ird", cpu_instr_readdata, 0);
    check("rst_drd", cpu_data_readdata, 0);
    check("rst_cke", cpu_clk_enable, 0);
    check("rst_err", bus_error, 0);

    // Halted after reset release: no bus activity, no commits.
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("halt_cke", cpu_clk_enable, 0);
      check("halt_read", bus_if.bus_read, 0);
    end
    check("halt_count", instr_count, 0);

    // NOP at reset vector, zero wait states. Cycle 0 = IDLE.
    cpu_instr_address = 32'hBFC0_0000;
    bus_if.bus_readdata = 32'h0000_0000;
    cpu_active = 1'b1;
    step(); // cycle 1 FETCH
    check("nop_read", bus_if.bus_read, 1);
    check("nop_addr", bus_if.bus_address, 32'hBFC0_0000);
    check("nop_write", bus_if.bus_write, 0);
    check("nop_cke1", cpu_clk_enable, 0);
    step(); // cycle 2 DECODE
    check("nop_read_dec", bus_if.bus_read, 0);
    check("nop_cke2", cpu_clk_enable, 0);
    step(); // cycle 3 COMMIT
    check("nop_cke3", cpu_clk_enable, 1);
    check("nop_read_cmt", bus_if.bus_read, 0);
    step(); // cycle 4 IDLE
    check("nop_cke4", cpu_clk_enable, 0);
    check("nop_count", instr_count, 1);

    // Load: 3 stalled data cycles, 8 cycles total (IDLE at 4, COMMIT at 11).
    cpu_instr_address = 32'hBFC0_0004;
    bus_if.bus_readdata = 32'h8C00_0004;
    step(); // cycle 5 FETCH
    check("ld_fetch_read", bus_if.bus_read, 1);
    check("ld_fetch_addr", bus_if.bus_address, 32'hBFC0_0004);
    cpu_data_read = 1'b1;
    cpu_data_address = 32'h0000_1004;
    step(); // cycle 6 DECODE
    check("ld_ird", cpu_instr_readdata, 32'h8C00_0004);
    check("ld_dec_read", bus_if.bus_read, 0);
    bus_if.bus_waitrequest = 1'b1;
    bus_if.bus_readdata = 32'h0BAD_F00D;
    step(); // cycle 7 DATA wait 1
    check("ld_data_read", bus_if.bus_read, 1);
    check("ld_data_addr", bus_if.bus_address, 32'h0000_1004);
    check("ld_data_write", bus_if.bus_write, 0);
    step(); // cycle 8 wait 2
    step(); // cycle 9 wait 3
    check("ld_hold_read", bus_if.bus_read, 1);
    check("ld_hold_addr", bus_if.bus_address, 32'h0000_1004);
    check("ld_hold_cke", cpu_clk_enable, 0);
    step(); // cycle 10 DATA completes
    check("ld_no_early_cap", cpu_data_readdata, 0);
    bus_if.bus_waitrequest = 1'b0;
    bus_if.bus_readdata = 32'hDEAD_BEEF;
    step(); // cycle 11 COMMIT
    check("ld_drd", cpu_data_readdata, 32'hDEAD_BEEF);
    check("ld_cke", cpu_clk_enable, 1);
    check("ld_cmt_read", bus_if.bus_read, 0);
    cpu_data_read = 1'b0;
    step(); // cycle 12 IDLE
    check("ld_count", instr_count, 2);
    check("ld_idle_cke", cpu_clk_enable, 0);

    // Store with read+write both asserted: write wins.
    cpu_instr_address = 32'hBFC0_0008;
    bus_if.bus_readdata = 32'hAC00_0010;
    step(); // FETCH
    check("st_fetch_addr", bus_if.bus_address, 32'hBFC0_0008);
    cpu_data_read = 1'b1;
    cpu_data_write = 1'b1;
    cpu_data_address = 32'h0000_0010;
    cpu_data_writedata = 32'h1234_5678;
    step(); // DECODE
    check("st_ird", cpu_instr_readdata, 32'hAC00_0010);
    bus_if.bus_readdata = 32'h5555_5555;
    step(); // DATA
    check("st_write", bus_if.bus_write, 1);
    check("st_read", bus_if.bus_read, 0);
    check("st_addr", bus_if.bus_address, 32'h0000_0010);
    check("st_wdata", bus_if.bus_writedata, 32'h1234_5678);
    step(); // COMMIT
    check("st_write_drop", bus_if.bus_write, 0);
    check("st_cke", cpu_clk_enable, 1);
    check("st_drd_kept", cpu_data_readdata, 32'hDEAD_BEEF);
    cpu_active = 1'b0;
    cpu_data_read = 1'b0;
    cpu_data_write = 1'b0;
    step(); // IDLE
    check("st_count", instr_count, 3);
    step();
    check("park_read", bus_if.bus_read, 0);
    check("park_cke", cpu_clk_enable, 0);

    // Reset during a stalled fetch; cpu_active drop mid-fetch must not matter.
    cpu_instr_address = 32'hBFC0_0100;
    bus_if.bus_waitrequest = 1'b1;
    cpu_active = 1'b1;
    step(); // FETCH stalled
    check("rf_read", bus_if.bus_read, 1);
    cpu_active = 1'b0;
    step();
    check("rf_hold", bus_if.bus_read, 1);
    #2;
    reset = 1'b0;
    #1;
    check("rf_async_read", bus_if.bus_read, 0);
    check("rf_count", instr_count, 0);
    check("rf_ird", cpu_instr_readdata, 0);
    check("rf_drd", cpu_data_readdata, 0);
    #1;
    reset = 1'b1;
    bus_if.bus_waitrequest = 1'b0;
    bus_if.bus_readdata = 32'h0000_0020;
    cpu_active = 1'b1;
    step(); // FETCH
    check("rf_refetch_read", bus_if.bus_read, 1);
    check("rf_refetch_addr", bus_if.bus_address, 32'hBFC0_0100);
    cpu_active = 1'b0;
    step(); // DECODE
    check("rf_ird2", cpu_instr_readdata, 32'h0000_0020);
    step(); // COMMIT
    check("rf_cke", cpu_clk_enable, 1);
    step(); // IDLE, parked
    check("rf_count2", instr_count, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rf_park_read", bus_if.bus_read, 0);
      check("rf_park_cke", cpu_clk_enable, 0);
    end
    check("rf_err", bus_error, 0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Timeout after 8 stalled cycles; error is sticky until reset.
    bus_if.bus_waitrequest = 1'b1;
    cpu_active = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check("to_read_held", bus_if.bus_read, 1);
      check("to_err_low", bus_error, 0);
    end
    step();
    check("to_read_drop", bus_if.bus_read, 0);
    check("to_err", bus_error, 1);
    bus_if.bus_waitrequest = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("to_cke", cpu_clk_enable, 0);
      check("to_read", bus_if.bus_read, 0);
      check("to_sticky", bus_error, 1);
    end
    reset = 1'b0;
    cpu_active = 1'b0;
    #1;
    check("to_rst_err", bus_error, 0);
    reset = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Multicycle sequencer that shares one single-port memory bus between the Harvard CPU's instruction and data ports.
- Per instruction, in order: fetch at cpu_instr_address, present the latched instruction for one decode cycle, perform at most one data access, then pulse cpu_clk_enable for one cycle to commit.
- Sits between mips_cpu_harvard and the Avalon-style memory bus, and owns the CPU's clock enable.

Parameters:
- TIMEOUT_CYCLES, 256: waitrequest-high cycles tolerated per bus access (used only with MEM_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_active  in  1  CPU active flag; low stops new fetches
- cpu_clk_enable  out  1  one-cycle commit pulse to CPU
- cpu_instr_address  in  32  CPU fetch address (PC)
- cpu_instr_readdata  out  32  latched instruction word
- cpu_data_address  in  32  CPU data address
- cpu_data_read  in  1  CPU data read request
- cpu_data_write  in  1  CPU data write request
- cpu_data_writedata  in  32  CPU store data
- cpu_data_readdata  out  32  latched load data
- bus_address  out  32  memory bus byte address
- bus_read  out  1  bus read strobe
- bus_write  out  1  bus write strobe
- bus_writedata  out  32  bus store data
- bus_waitrequest  in  1  memory stall; access completes in the first cycle it is low
- bus_readdata  in  32  valid when bus_read=1 and bus_waitrequest=0
- instr_count  out  32  committed-instruction counter
- bus_error  out  1  sticky timeout flag

Behaviour:
- States: IDLE, FETCH, DECODE, DATA, COMMIT, ERR (ERR exists only with the macro).
- Reset (asynchronous, reset=0):
  - State goes to IDLE.
  - All outputs, including both readdata latches, instr_count and bus_error, go to 0.
  - Any in-flight bus access is abandoned; strobes drop immediately, not at the next edge.
- All bus_* and cpu_* outputs are registered, except cpu_clk_enable, which is decoded from state==COMMIT.
- IDLE:
  - cpu_active=1: load bus_address<=cpu_instr_address, bus_read<=1, go to FETCH.
  - cpu_active=0: stay in IDLE (halted); the bus stays idle.
- FETCH:
  - Hold all bus signals while bus_waitrequest=1.
  - On waitrequest=0: cpu_instr_readdata<=bus_readdata, bus_read<=0, go to DECODE.
- DECODE: exactly one cycle, so the CPU can decode the latched instruction combinationally. At the end of the cycle:
  - cpu_data_write=1: bus_write<=1 with bus_address<=cpu_data_address and bus_writedata<=cpu_data_writedata; go to DATA.
  - else cpu_data_read=1: bus_read<=1 with bus_address<=cpu_data_address; go to DATA.
  - Write wins if read and write are both asserted; the read is dropped and cpu_data_readdata is unchanged.
  - Neither asserted: go to COMMIT.
- DATA:
  - Hold all bus signals while waitrequest=1.
  - On waitrequest=0: a read captures cpu_data_readdata<=bus_readdata; both strobes go to 0; go to COMMIT.
- COMMIT:
  - cpu_clk_enable=1 for exactly this cycle.
  - instr_count increments by 1, wrapping 0xFFFFFFFF to 0.
  - Next state is IDLE.
- Latency at zero wait states: 4 cycles per instruction without a data access (IDLE, FETCH, DECODE, COMMIT); 5 cycles with one.
- Bus invariants:
  - bus_read and bus_write are never both 1.
  - Strobes are never asserted outside FETCH and DATA.
  - Addresses pass through unmodified.
- cpu_active falling mid-instruction: the current instruction completes and commits; the arbiter then parks in IDLE.
- cpu_instr_readdata and cpu_data_readdata hold their last values between updates.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to FETCH/DATA and increments each cycle bus_waitrequest=1.
  - When it reaches TIMEOUT_CYCLES: both strobes drop, bus_error<=1, state goes to ERR.
  - ERR is terminal until reset: no further bus activity; cpu_clk_enable stays 0.
- Undefined: accesses wait indefinitely; bus_error is tied to 0; no ERR state and no counter.

Test Plan:
- Reset release with cpu_active=0 -> stays in IDLE; all strobes 0; instr_count=0; no cpu_clk_enable pulse over 20 cycles.
- cpu_active=1, PC=0xBFC00000, zero-wait memory returns 0x00000000 (NOP) -> bus_read with address 0xBFC00000 on cycle 1; cpu_clk_enable pulse on cycle 3; instr_count=1; period 4 cycles.
- Load: instruction latched, CPU asserts cpu_data_read with address 0x00001004; memory returns 0xDEADBEEF after 3 waitrequest cycles -> cpu_data_readdata=0xDEADBEEF before the commit pulse; total 8 cycles.
- Store with cpu_data_read=cpu_data_write=1, address 0x10, data 0x12345678 -> exactly one bus_write cycle with that address and data; bus_read never high in DATA; cpu_data_readdata unchanged.
- Reset asserted while FETCH is stalled by waitrequest -> bus_read drops asynchronously; after release, the next fetch reissues cpu_instr_address; instr_count=0.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, waitrequest held high -> strobes drop after 8 wait cycles; bus_error=1 and sticky; no further cpu_clk_enable until reset.
